// File: rtl/uart_tx.sv
// uart_tx: serializes D_WIDTH-bit words into start/data(LSB first)/stop frames.
// Latency: tx falls one cycle after a word is accepted from an idle line; each
//   bit lasts BAUD_CNT_MAX+1 cycles, one frame is (D_WIDTH+2)*(BAUD_CNT_MAX+1) cycles.
// Backpressure: one-entry holding register; tx_ready low while it is full, and a
//   pi_flag presented while tx_ready is low is dropped (never overwrites).
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  synchronous active-low reset (aborts any frame, drops queued word)
//   pi_data    parallel word to send
//   pi_flag    word valid, accepted when tx_ready is high
//   tx_ready   holding register empty
//   tx         registered serial line, idles high
//   tx_busy    a frame is in progress
//   tx_done    one-cycle pulse at the end of each stop bit
module uart_tx #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int D_WIDTH   = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [D_WIDTH-1:0] pi_data,
  input  logic               pi_flag,
  output logic               tx_ready,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int BAUD_CNT_MAX = (CLK_FREQ / BAUD_RATE) - 1;
  localparam logic [14:0] BAUD_LAST = 15'(BAUD_CNT_MAX);

  localparam int BCW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(D_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         state_q,    state_d;
  logic [14:0]        baud_cnt_q, baud_cnt_d;
  logic [BCW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [D_WIDTH-1:0] shift_q,    shift_d;
  logic [D_WIDTH-1:0] hold_dat_q, hold_dat_d;
  logic               hold_vld_q, hold_vld_d;
  logic               tx_q,       tx_d;
  logic               done_q,     done_d;

  logic               baud_end;
  logic               consume;
  logic               accept;
  logic [D_WIDTH-1:0] shift_nxt;

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  assign shift_nxt = shift_q >> 1;
  assign accept    = pi_flag & ~hold_vld_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    consume    = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (hold_vld_q) begin
          consume = 1'b1;
          shift_d = hold_dat_q;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 15'd1;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_nxt;
          if (bit_cnt_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // The bit after the shift is the next one on the line.
            tx_d      = shift_nxt[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 15'd1;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          done_d     = 1'b1;
          if (hold_vld_q) begin
            // Chain straight into the next start bit: no idle gap.
            consume = 1'b1;
            shift_d = hold_dat_q;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 15'd1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // Consume reads the old contents; an accept in the same cycle (only possible
  // when the register was empty, so never in practice together with consume)
  // is applied last and leaves the new word held.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (consume) begin
      hold_vld_d = 1'b0;
    end
    if (accept) begin
      hold_vld_d = 1'b1;
      hold_dat_d = pi_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hold_dat_q <= '0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_dat_q <= hold_dat_d;
      hold_vld_q <= hold_vld_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = ~hold_vld_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign tx_done  = done_q;

endmodule
